// File: rtl/freq_cnt_pkg.sv
// Shared types and default widths for the gated frequency counter.
package freq_cnt_pkg;

  localparam int unsigned DEF_DATA_WIDTH = 14;
  localparam int unsigned DEF_N_WIDTH    = 32;
  localparam int unsigned DEF_CNT_WIDTH  = 32;

  localparam logic [DEF_CNT_WIDTH-1:0] CNT_MAX = '1;

  typedef enum logic {
    StIdle,
    StRun
  } state_e;

endpackage

// File: rtl/hyst_cmp.sv
// Input register, hysteresis comparator and rising-crossing detector.
// rise_o is high in the cycle after the sample that completed the crossing was in s1.
module hyst_cmp #(
  parameter int unsigned DATA_WIDTH = 14
) (
  input  logic                         clk_i,
  input  logic                         rstn_i,
  input  logic signed [DATA_WIDTH-1:0] adc_i,
  input  logic signed [DATA_WIDTH-1:0] thr_hi_i,
  input  logic signed [DATA_WIDTH-1:0] thr_lo_i,
  output logic                         rise_o
);

  logic signed [DATA_WIDTH-1:0] s1_q;
  logic                         cmp_d, cmp_q, cmp_prev_q;

  // Set wins over clear, so crossed thresholds behave as a plain comparator at thr_hi.
  always_comb begin
    cmp_d = cmp_q;
    if (s1_q >= thr_hi_i) begin
      cmp_d = 1'b1;
    end else if (s1_q <= thr_lo_i) begin
      cmp_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      s1_q       <= '0;
      cmp_q      <= 1'b0;
      cmp_prev_q <= 1'b0;
    end else begin
      s1_q       <= adc_i;
      cmp_q      <= cmp_d;
      cmp_prev_q <= cmp_q;
    end
  end

  assign rise_o = cmp_q & ~cmp_prev_q;

endmodule

// File: rtl/freq_gate_counter.sv
// Counts hysteresis-qualified rising crossings over back-to-back gates of N_i cycles.
// Gate tags travel one stage behind the samples so every crossing lands in its own gate.
module freq_gate_counter
  import freq_cnt_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned N_WIDTH    = DEF_N_WIDTH,
  parameter int unsigned CNT_WIDTH  = DEF_CNT_WIDTH
) (
  input  logic                         clk_i,
  input  logic                         rstn_i,
  input  logic signed [DATA_WIDTH-1:0] adc_i,
  input  logic signed [DATA_WIDTH-1:0] thr_hi_i,
  input  logic signed [DATA_WIDTH-1:0] thr_lo_i,
  input  logic        [N_WIDTH-1:0]    N_i,
  input  logic                         en_i,
  output logic        [CNT_WIDTH-1:0]  count_o,
  output logic        [N_WIDTH-1:0]    n_o,
  output logic                         sat_o,
  output logic                         count_valid_o,
  output logic                         busy_o
);

  localparam logic [CNT_WIDTH-1:0] CntMax = '1;

  state_e               state_q, state_d;
  logic [N_WIDTH-1:0]   gate_q, n_lat_q;
  logic                 start, gate_last, gate_load, rise;

  logic                 tag_vld_q, tag_first_q, tag_last_q;
  logic [N_WIDTH-1:0]   tag_n_q;
  logic [CNT_WIDTH-1:0] acc_q;
  logic                 acc_sat_q, done_q;
  logic [N_WIDTH-1:0]   done_n_q;
  logic [CNT_WIDTH-1:0] count_q;
  logic [N_WIDTH-1:0]   n_q;
  logic                 sat_q, valid_q;

  hyst_cmp #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_hyst_cmp (
    .clk_i    (clk_i),
    .rstn_i   (rstn_i),
    .adc_i    (adc_i),
    .thr_hi_i (thr_hi_i),
    .thr_lo_i (thr_lo_i),
    .rise_o   (rise)
  );

  assign start     = en_i && (N_i != '0);
  assign gate_last = (state_q == StRun) && (gate_q == n_lat_q - N_WIDTH'(1));
  assign gate_load = ((state_q == StIdle) || gate_last) && start;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // A completed gate finishes even if en_i drops on its last cycle.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (start) state_d = StRun;
      StRun: begin
        if (gate_last) begin
          state_d = start ? StRun : StIdle;
        end else if (!en_i) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    busy_o = (state_q == StRun);
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      gate_q  <= '0;
      n_lat_q <= '0;
    end else if (gate_load) begin
      gate_q  <= '0;
      n_lat_q <= N_i;
    end else if (state_q == StRun) begin
      gate_q  <= gate_q + N_WIDTH'(1);
    end
  end

  // Stage 1 tags the sample now in s1; stage 2 meets its rise; stage 3 publishes.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      tag_vld_q   <= 1'b0;
      tag_first_q <= 1'b0;
      tag_last_q  <= 1'b0;
      tag_n_q     <= '0;
      acc_q       <= '0;
      acc_sat_q   <= 1'b0;
      done_q      <= 1'b0;
      done_n_q    <= '0;
      count_q     <= '0;
      n_q         <= '0;
      sat_q       <= 1'b0;
      valid_q     <= 1'b0;
    end else begin
      tag_vld_q   <= (state_q == StRun);
      tag_first_q <= (state_q == StRun) && (gate_q == '0);
      tag_last_q  <= gate_last;
      tag_n_q     <= n_lat_q;

      if (tag_vld_q) begin
        if (tag_first_q) begin
          acc_q     <= CNT_WIDTH'(rise);
          acc_sat_q <= 1'b0;
        end else if (rise) begin
          if (acc_q == CntMax) begin
            acc_sat_q <= 1'b1;
          end else begin
            acc_q <= acc_q + CNT_WIDTH'(1);
          end
        end
      end
      done_q   <= tag_vld_q && tag_last_q;
      done_n_q <= tag_n_q;

      valid_q <= done_q;
      if (done_q) begin
        count_q <= acc_q;
        n_q     <= done_n_q;
        sat_q   <= acc_sat_q;
      end
    end
  end

  assign count_o       = count_q;
  assign n_o           = n_q;
  assign sat_o         = sat_q;
  assign count_valid_o = valid_q;

endmodule

// File: tb/tb_freq_gate_counter.sv
// Directed bench for freq_gate_counter: a default-width instance plus a 4-bit counter instance.
module tb_freq_gate_counter;

  logic               clk = 1'b0;
  logic               rstn;
  logic signed [13:0] adc, thr_hi, thr_lo;
  logic [31:0]        n_in, n_s;
  logic               en, en_s;

  logic [31:0] count, n_out, n_out_s;
  logic [3:0]  count_s;
  logic        sat, valid, busy, sat_s, valid_s, busy_s;

  freq_gate_counter dut (
    .clk_i         (clk),
    .rstn_i        (rstn),
    .adc_i         (adc),
    .thr_hi_i      (thr_hi),
    .thr_lo_i      (thr_lo),
    .N_i           (n_in),
    .en_i          (en),
    .count_o       (count),
    .n_o           (n_out),
    .sat_o         (sat),
    .count_valid_o (valid),
    .busy_o        (busy)
  );

  freq_gate_counter #(
    .CNT_WIDTH (4)
  ) dut_s (
    .clk_i         (clk),
    .rstn_i        (rstn),
    .adc_i         (adc),
    .thr_hi_i      (thr_hi),
    .thr_lo_i      (thr_lo),
    .N_i           (n_s),
    .en_i          (en_s),
    .count_o       (count_s),
    .n_o           (n_out_s),
    .sat_o         (sat_s),
    .count_valid_o (valid_s),
    .busy_o        (busy_s)
  );

  always #5 clk = ~clk;

  int edges = 0;
  always @(posedge clk) edges <= edges + 1;

  int total = 0;
  int bad   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Stimulus: 0 = DC, 1 = square of period per, 2 = square of period 32 with chatter.
  int                 mode = 0;
  int                 per  = 16;
  int                 ph   = 0;
  logic signed [13:0] dc_val = -14'sd4000;

  function automatic logic signed [13:0] gen(input int m, input int p, input int pr,
                                             input logic signed [13:0] dc);
    int h;
    if (m == 0) return dc;
    if (m == 1) return ((p % pr) < (pr / 2)) ? 14'sd4000 : -14'sd4000;
    h = p % 32;
    if (h < 16) begin
      if (h == 0 || h == 2) return 14'sd500;
      if (h == 1) return -14'sd500;
      return 14'sd4000;
    end
    if (h == 16 || h == 18) return -14'sd500;
    if (h == 17) return 14'sd500;
    return -14'sd4000;
  endfunction

  int          nval = 0, nval_s = 0, r_t = 0;
  logic [31:0] r_cnt, r_n;
  logic        r_sat;
  logic [3:0]  rs_cnt;
  logic        rs_sat;

  task automatic step();
    @(negedge clk);
    if (valid === 1'b1) begin
      nval++;
      r_cnt = count;
      r_n   = n_out;
      r_sat = sat;
      r_t   = edges;
    end
    if (valid_s === 1'b1) begin
      nval_s++;
      rs_cnt = count_s;
      rs_sat = sat_s;
    end
    adc = gen(mode, ph, per, dc_val);
    ph++;
  endtask

  task automatic wait_pulse(input int bound, output bit ok);
    int n0 = nval;
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      step();
      if (nval != n0) begin
        ok = 1'b1;
        return;
      end
    end
  endtask

  task automatic wait_pulse_s(input int bound, output bit ok);
    int n0 = nval_s;
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      step();
      if (nval_s != n0) begin
        ok = 1'b1;
        return;
      end
    end
  endtask

  bit ok;
  int t_en, t_prev, nv;

  initial begin
    rstn   = 1'b0;
    en     = 1'b0;
    en_s   = 1'b0;
    n_in   = '0;
    n_s    = '0;
    thr_hi = 14'sd1000;
    thr_lo = -14'sd1000;
    adc    = dc_val;
    repeat (3) step();
    check_eq("rst_count", 64'(count), 64'd0);
    check_eq("rst_n", 64'(n_out), 64'd0);
    check_eq("rst_sat", 64'(sat), 64'd0);
    check_eq("rst_valid", 64'(valid), 64'd0);
    check_eq("rst_busy", 64'(busy), 64'd0);
    rstn = 1'b1;
    repeat (4) step();

    // Clean square wave, N=1024
    mode = 1; per = 16;
    repeat (20) step();
    n_in = 32'd1024;
    en   = 1'b1;
    t_en = edges;
    wait_pulse(1100, ok);
    check_eq("t1_wait", 64'(ok), 64'd1);
    check_eq("t1_latency", 64'(r_t - t_en), 64'd1027);
    check_eq("t1_count", 64'(r_cnt), 64'd64);
    check_eq("t1_n", 64'(r_n), 64'd1024);
    check_eq("t1_sat", 64'(r_sat), 64'd0);
    t_prev = r_t;
    wait_pulse(1100, ok);
    check_eq("t1_wait2", 64'(ok), 64'd1);
    check_eq("t1_spacing", 64'(r_t - t_prev), 64'd1024);
    check_eq("t1_count2", 64'(r_cnt), 64'd64);
    en = 1'b0;
    repeat (3) step();

    // Chatter around transitions, with and without hysteresis
    mode = 2;
    n_in = 32'd256;
    repeat (40) step();
    en = 1'b1;
    wait_pulse(400, ok);
    check_eq("t2_wait", 64'(ok), 64'd1);
    check_eq("t2_count_hyst", 64'(r_cnt), 64'd8);
    en = 1'b0;
    thr_hi = 14'sd0;
    thr_lo = 14'sd0;
    repeat (40) step();
    en = 1'b1;
    wait_pulse(400, ok);
    check_eq("t2_wait_nohyst", 64'(ok), 64'd1);
    check_eq("t2_count_nohyst", 64'(r_cnt), 64'd24);
    en = 1'b0;
    thr_hi = 14'sd1000;
    thr_lo = -14'sd1000;
    repeat (3) step();

    // 4-bit counter saturation, then a DC gate
    mode = 1; per = 2;
    repeat (10) step();
    n_s  = 32'd64;
    en_s = 1'b1;
    wait_pulse_s(200, ok);
    check_eq("t3_wait", 64'(ok), 64'd1);
    check_eq("t3_count_sat", 64'(rs_cnt), 64'd15);
    check_eq("t3_sat", 64'(rs_sat), 64'd1);
    en_s = 1'b0;
    mode = 0;
    repeat (10) step();
    en_s = 1'b1;
    wait_pulse_s(200, ok);
    check_eq("t3_wait_dc", 64'(ok), 64'd1);
    check_eq("t3_count_dc", 64'(rs_cnt), 64'd0);
    check_eq("t3_sat_dc", 64'(rs_sat), 64'd0);
    en_s = 1'b0;

    // N_i changed mid-gate
    mode = 1; per = 16;
    n_in = 32'd256;
    repeat (20) step();
    en = 1'b1;
    repeat (100) step();
    check_eq("t4_busy_high", 64'(busy), 64'd1);
    n_in = 32'd512;
    wait_pulse(400, ok);
    check_eq("t4_wait", 64'(ok), 64'd1);
    check_eq("t4_n_old", 64'(r_n), 64'd256);
    check_eq("t4_count_old", 64'(r_cnt), 64'd16);
    t_prev = r_t;
    wait_pulse(600, ok);
    check_eq("t4_wait2", 64'(ok), 64'd1);
    check_eq("t4_n_new", 64'(r_n), 64'd512);
    check_eq("t4_count_new", 64'(r_cnt), 64'd32);
    check_eq("t4_spacing", 64'(r_t - t_prev), 64'd512);

    // Abort mid-gate, then re-enable
    repeat (100) step();
    en = 1'b0;
    nv = nval;
    step();
    check_eq("t5_busy_low", 64'(busy), 64'd0);
    repeat (700) step();
    check_eq("t5_no_pulse", 64'(nval - nv), 64'd0);
    check_eq("t5_count_hold", 64'(count), 64'd32);
    check_eq("t5_n_hold", 64'(n_out), 64'd512);
    n_in = 32'd256;
    en   = 1'b1;
    t_en = edges;
    wait_pulse(400, ok);
    check_eq("t5_wait", 64'(ok), 64'd1);
    check_eq("t5_latency", 64'(r_t - t_en), 64'd259);
    check_eq("t5_count", 64'(r_cnt), 64'd16);
    en = 1'b0;
    repeat (3) step();
    n_in = '0;
    en   = 1'b1;
    repeat (10) step();
    check_eq("t5_n0_busy", 64'(busy), 64'd0);
    en = 1'b0;

    // Asynchronous reset mid-gate
    n_in = 32'd256;
    repeat (3) step();
    en = 1'b1;
    repeat (100) step();
    rstn = 1'b0;
    #1;
    check_eq("t6_rst_count", 64'(count), 64'd0);
    check_eq("t6_rst_n", 64'(n_out), 64'd0);
    check_eq("t6_rst_busy", 64'(busy), 64'd0);
    check_eq("t6_rst_valid", 64'(valid), 64'd0);
    repeat (2) step();
    rstn = 1'b1;
    t_en = edges;
    wait_pulse(400, ok);
    check_eq("t6_wait", 64'(ok), 64'd1);
    check_eq("t6_latency", 64'(r_t - t_en), 64'd259);
    check_eq("t6_n", 64'(r_n), 64'd256);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
